// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration chain: loader state encoding
// and default chain/word sizing derived from tile geometry.
package fabric_cfg_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  localparam int DEFAULT_WORD_WIDTH = 8;

  // Switch box geometry: four sides, WIDTH tracks each, SEL_BITS per mux.
  localparam int SB_WIDTH    = 2;
  localparam int SB_SEL_BITS = 2;

  function automatic int sb_chain_length(input int width, input int sel_bits);
    return 4 * width * sel_bits;
  endfunction

  localparam int DEFAULT_CHAIN_LENGTH = sb_chain_length(SB_WIDTH, SB_SEL_BITS);

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in/serial-out word register feeding the configuration chain, with a
// per-word bit counter so the final word can be cut short.
module cfg_piso
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic                               config_clk,
  input  logic                               config_rst_n,
  input  logic                               load,
  input  logic                               shift,
  input  logic [WORD_WIDTH-1:0]              data,
  input  logic [$clog2(WORD_WIDTH+1)-1:0]    count,
  output logic                               serial,
  output logic                               word_last
);

  localparam int WLW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] shreg;
  logic [WLW-1:0]        word_left;

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) begin
      shreg     <= '0;
      word_left <= '0;
    end else if (load) begin
      shreg     <= data;
      word_left <= count;
    end else if (shift) begin
      shreg     <= {1'b0, shreg[WORD_WIDTH-1:1]};
      word_left <= word_left - WLW'(1);
    end
  end

  assign serial    = shreg[0];
  assign word_last = (word_left == WLW'(1));

endmodule

// File: rtl/config_loader.sv
// Bitstream loader: accepts words over valid/ready and shifts exactly
// CHAIN_LENGTH bits, LSB first, into the fabric configuration chain.
//
//   state | meaning
//   IDLE  | waiting for start; done holds result of last load
//   FILL  | data_ready high, waiting for the next word
//   SHIFT | one chain bit per cycle until the current word is exhausted
module config_loader
  import fabric_cfg_pkg::*;
#(
  parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
  parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH
) (
  input  logic                  config_clk,
  input  logic                  config_rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_out,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done
);

  localparam int BLW = $clog2(CHAIN_LENGTH + 1);
  localparam int WLW = $clog2(WORD_WIDTH + 1);

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic [BLW-1:0] bits_left;
  logic [WLW-1:0] word_count;
  logic           start_load;
  logic           accept;
  logic           shifting;
  logic           word_last;
  logic           chain_last;

  assign start_load = (state == IDLE) && start;
  assign accept     = (state == FILL) && data_valid;
  assign shifting   = (state == SHIFT);
  assign chain_last = shifting && word_last && (bits_left == BLW'(1));

  // The final word is truncated to whatever is left of the chain.
  always_comb begin
    word_count = WLW'(WORD_WIDTH);
    if (int'(bits_left) < WORD_WIDTH) word_count = WLW'(bits_left);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (data_valid) state_nxt = SHIFT;
      SHIFT:   if (word_last) state_nxt = (bits_left == BLW'(1)) ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n)   bits_left <= '0;
    else if (start_load) bits_left <= BLW'(CHAIN_LENGTH);
    else if (shifting)   bits_left <= bits_left - BLW'(1);
  end

  always_ff @(posedge config_clk or negedge config_rst_n) begin
    if (!config_rst_n)   done <= 1'b0;
    else if (start_load) done <= 1'b0;
    else if (chain_last) done <= 1'b1;
  end

  cfg_piso #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_piso (
    .config_clk  (config_clk),
    .config_rst_n(config_rst_n),
    .load        (accept),
    .shift       (shifting),
    .data        (data_in),
    .count       (word_count),
    .serial      (config_out),
    .word_last   (word_last)
  );

  assign data_ready = (state == FILL);
  assign config_en  = shifting;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a 16-bit and a 12-bit chain instance
// share data/valid; each load is compared against an arithmetic bit-order model.
module tb_config_loader;

  logic       clk;
  logic       rst_n;
  logic       start16;
  logic       start12;
  logic       data_valid;
  logic [7:0] data_in;
  logic       ready16, out16, en16, busy16, done16;
  logic       ready12, out12, en12, busy12, done12;

  int checks   = 0;
  int failures = 0;

  config_loader dut16 (
    .config_clk  (clk),
    .config_rst_n(rst_n),
    .start       (start16),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (ready16),
    .config_out  (out16),
    .config_en   (en16),
    .busy        (busy16),
    .done        (done16)
  );

  config_loader #(
    .WORD_WIDTH  (8),
    .CHAIN_LENGTH(12)
  ) dut12 (
    .config_clk  (clk),
    .config_rst_n(rst_n),
    .start       (start12),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (ready12),
    .config_out  (out12),
    .config_en   (en12),
    .busy        (busy12),
    .done        (done12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel12;
    logic [7:0] w0;
    logic [7:0] w1;
    int         stall0;
    int         stall1;
    int         poke;
    logic [15:0] exp_seq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bit i of the result is the i-th bit to leave the loader.
  function automatic logic [15:0] model_bits(input logic [7:0] w0, input logic [7:0] w1, input int len);
    logic [15:0] seq;
    seq = '0;
    for (int i = 0; i < len; i++) begin
      if (i < 8) seq[i] = w0[i];
      else       seq[i] = w1[i-8];
    end
    return seq;
  endfunction

  task automatic run_load(input string tag, input bit sel12, input logic [7:0] w0,
                          input logic [7:0] w1, input int stall0, input int stall1,
                          input int poke, input logic [15:0] exp_seq);
    int len, nwords, nbits, fills, en_in_fill, done_cyc, widx, stall_left, cyc, late_bad;
    logic [15:0] got, chain, img, mask;
    logic r, e, o, b, d;
    len = sel12 ? 12 : 16;
    nwords = (len + 7) / 8;
    nbits = 0; fills = 0; en_in_fill = 0; done_cyc = -1; widx = 0;
    stall_left = stall0; late_bad = 0;
    got = '0; chain = '0; img = '0; mask = '0;
    for (int i = 0; i < len; i++) begin
      img[len-1-i] = exp_seq[i];
      mask[i] = 1'b1;
    end

    @(negedge clk);
    start16 = !sel12;
    start12 = sel12;
    data_valid = 1'b1;
    data_in = w0;

    cyc = 0;
    while (done_cyc < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      r = sel12 ? ready12 : ready16;
      e = sel12 ? en12    : en16;
      o = sel12 ? out12   : out16;
      b = sel12 ? busy12  : busy16;
      d = sel12 ? done12  : done16;
      if (cyc == 1) begin
        check({tag, "_fill_ready"}, r, 1'b1);
        check({tag, "_fill_busy"},  b, 1'b1);
        check({tag, "_done_clr"},   d, 1'b0);
        check({tag, "_fill_en"},    e, 1'b0);
      end
      if (e) begin
        if (nbits < 16) got[nbits] = o;
        chain = {chain[14:0], o};
        nbits++;
      end
      if (r) begin
        fills++;
        if (e) en_in_fill++;
      end
      if (d) done_cyc = cyc;
      start16 = 1'b0;
      start12 = 1'b0;
      if (cyc == poke) begin
        start16 = !sel12;
        start12 = sel12;
      end
      data_valid = 1'b1;
      data_in = (widx == 0) ? w0 : (widx == 1) ? w1 : 8'hFF;
      if (r && widx < nwords) begin
        if (stall_left > 0) begin
          stall_left--;
          data_valid = 1'b0;
        end else begin
          widx++;
          stall_left = stall1;
        end
      end
    end
    start16 = 1'b0;
    start12 = 1'b0;

    check({tag, "_done_cycle"}, done_cyc, nwords + len + 1 + stall0 + stall1);
    check({tag, "_bit_count"},  nbits, len);
    check({tag, "_bit_seq"},    got, exp_seq);
    check({tag, "_chain_img"},  chain & mask, img);
    check({tag, "_fill_cycles"}, fills, nwords + stall0 + stall1);
    check({tag, "_en_in_fill"}, en_in_fill, 0);

    data_valid = 1'b1;
    data_in = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sel12) begin
        if (ready12 || en12 || busy12 || !done12) late_bad++;
      end else begin
        if (ready16 || en16 || busy16 || !done16) late_bad++;
      end
    end
    check({tag, "_idle_after_done"}, late_bad, 0);
  endtask

  initial begin
    vec_t vecs [6];

    rst_n = 1'b0; start16 = 1'b0; start12 = 1'b0; data_valid = 1'b0; data_in = '0;
    #3;
    check("rst_ready16", ready16, 1'b0);
    check("rst_en16",    en16,    1'b0);
    check("rst_out16",   out16,   1'b0);
    check("rst_busy16",  busy16,  1'b0);
    check("rst_done16",  done16,  1'b0);
    check("rst_outs12",  {ready12, en12, out12, busy12, done12}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 0, 0, -1, 16'h3CA5};
    vecs[1] = '{1'b0, 8'hA5, 8'h3C, 0, 5, -1, 16'h3CA5};
    vecs[2] = '{1'b0, 8'hA5, 8'h3C, 0, 0,  3, 16'h3CA5};
    vecs[3] = '{1'b1, 8'hFF, 8'h0F, 0, 0, -1, 16'h0FFF};
    vecs[4] = '{1'b1, 8'hFF, 8'hF0, 0, 0, -1, 16'h00FF};
    vecs[5] = '{1'b0, 8'h00, 8'hFF, 3, 1, -1, 16'hFF00};

    for (int i = 0; i < 6; i++)
      run_load($sformatf("vec%0d", i), vecs[i].sel12, vecs[i].w0, vecs[i].w1,
               vecs[i].stall0, vecs[i].stall1, vecs[i].poke, vecs[i].exp_seq);

    // Sticky done survives idle cycles; reset clears it.
    @(negedge clk);
    check("done_sticky", done16, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("rst_clears_done", done16, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted during the third SHIFT cycle.
    @(negedge clk);
    start16 = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_shift_en",  en16,  1'b1);
    check("mid_shift_bit", out16, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_en",    en16,    1'b0);
    check("async_rst_out",   out16,   1'b0);
    check("async_rst_busy",  busy16,  1'b0);
    check("async_rst_ready", ready16, 1'b0);
    check("async_rst_done",  done16,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_load("after_rst", 1'b0, 8'hA5, 8'h3C, 0, 0, -1, 16'h3CA5);

    for (int n = 0; n < 10; n++) begin
      bit s;
      logic [7:0] a;
      logic [7:0] c;
      int s0;
      int s1;
      s  = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      c  = 8'($urandom);
      s0 = int'($urandom_range(0, 3));
      s1 = int'($urandom_range(0, 3));
      run_load($sformatf("rnd%0d", n), s, a, c, s0, s1, -1, model_bits(a, c, s ? 12 : 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
